corr_spi_streamer: RTL and testbench

Parametrised successor to the single-channel correlator SPI path: captures signed I/Q accumulator results from CHANNELS correlator channels, queues them in a FIFO and streams each as a self-describing 56-bit frame over an SPI master link. Sits between the per-channel demod/accumulator blocks and the board SPI pins.

---
 rtl/corr_spi_streamer.sv | 210 +++++++++++++++++++++
 tb/tb_corr_spi_streamer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_spi_streamer.sv
// Multi-channel correlator result capture, record FIFO and SPI mode-0 frame streamer.
// Each record goes out as HEADER, channel, seq, I[15:0], Q[15:0], MSB first.
module corr_spi_streamer #(
  parameter int          CHANNELS   = 4,
  parameter int          ACC_W      = 14,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CLK_DIV    = 4,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS*ACC_W-1:0]           ch_i,
  input  logic [CHANNELS*ACC_W-1:0]           ch_q,
  input  logic [CHANNELS-1:0]                 ch_ready,
  input  logic                                ovf_clr,
  output logic                                spi_clk,
  output logic                                mosi,
  output logic                                spi_ss,
  output logic                                overflow,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                busy,
  output logic [2:0]                          fsm_state
);

  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW   = 40;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  function automatic logic [15:0] sext(input logic [ACC_W-1:0] v);
    return 16'($signed(v));
  endfunction

  // Capture side
  logic [ACC_W-1:0]    hold_i [CHANNELS];
  logic [ACC_W-1:0]    hold_q [CHANNELS];
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] drain_sel;
  logic [RW-1:0]       drain_rec;
  logic                push;
  logic                pop;

  // FIFO
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          fifo_full;
  logic [RW-1:0] rd_rec;

  assign fifo_full = (count == LW'(FIFO_DEPTH));
  assign rd_rec    = mem[rd_ptr];

  // Lowest-index pending channel wins; descending loop leaves it last.
  always_comb begin
    drain_sel = '0;
    drain_rec = '0;
    for (int n = CHANNELS - 1; n >= 0; n--) begin
      if (pending[n]) begin
        drain_sel    = '0;
        drain_sel[n] = 1'b1;
        drain_rec    = {8'(n), sext(hold_i[n]), sext(hold_q[n])};
      end
    end
    push = (|pending) && !fifo_full;
    if (!push) drain_sel = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        hold_i[n] <= '0;
        hold_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (ch_ready[n]) begin
          hold_i[n] <= ch_i[n*ACC_W +: ACC_W];
          hold_q[n] <= ch_q[n*ACC_W +: ACC_W];
        end
      end
      pending <= (pending & ~drain_sel) | ch_ready;
      // An overwrite in the same cycle as a clear keeps the flag set.
      if (|(ch_ready & pending & ~drain_sel)) overflow <= 1'b1;
      else if (ovf_clr)                       overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= drain_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

  assign fifo_level = count;

  // SPI framing FSM
  state_t            state, state_n;
  logic [DIVW-1:0]   div_cnt, div_n;
  logic [6:0]        half_cnt, half_n;
  logic [55:0]       shreg, shreg_n;
  logic [7:0]        seq, seq_n;
  logic              sclk_n, mosi_n, ss_n;
  logic              half_end;

  assign half_end = (div_cnt == DIVW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      shreg    <= '0;
      seq      <= '0;
      spi_clk  <= 1'b0;
      mosi     <= 1'b0;
      spi_ss   <= 1'b1;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      half_cnt <= half_n;
      shreg    <= shreg_n;
      seq      <= seq_n;
      spi_clk  <= sclk_n;
      mosi     <= mosi_n;
      spi_ss   <= ss_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = DIVW'(div_cnt + 1'b1);
    half_n  = half_cnt;
    shreg_n = shreg;
    seq_n   = seq;
    sclk_n  = spi_clk;
    mosi_n  = mosi;
    ss_n    = spi_ss;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        div_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          shreg_n = {HEADER, rd_rec[39:32], seq, rd_rec[31:0]};
          mosi_n  = HEADER[7];
          ss_n    = 1'b0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (half_end) begin
          div_n   = '0;
          half_n  = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // Even half-periods end with a rising edge, odd ones with a falling edge.
        if (half_end) begin
          div_n  = '0;
          half_n = half_cnt + 7'd1;
          if (!half_cnt[0]) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n  = 1'b0;
            shreg_n = {shreg[54:0], 1'b0};
            mosi_n  = shreg[54];
            if (half_cnt == 7'd111) state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (half_end) begin
          div_n   = '0;
          ss_n    = 1'b1;
          mosi_n  = 1'b0;
          seq_n   = seq + 8'd1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (half_end) begin
          div_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_corr_spi_streamer.sv
// Directed bench: a slow instance (CLK_DIV=4, depth 8) for framing/latency/reset,
// a fast instance (CLK_DIV=1, depth 2) for overflow and sequence wrap.
module tb_corr_spi_streamer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #50 clk = ~clk;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;

  logic [55:0] ch_i1 = '0, ch_q1 = '0, ch_i2 = '0, ch_q2 = '0;
  logic [3:0]  rdy1 = '0, rdy2 = '0;
  logic        clr1 = 1'b0, clr2 = 1'b0;
  logic        sclk1, mosi1, ss1, ovf1, busy1;
  logic        sclk2, mosi2, ss2, ovf2, busy2;
  logic [3:0]  lvl1;
  logic [1:0]  lvl2;
  logic [2:0]  st1, st2;

  corr_spi_streamer #(.CHANNELS(4), .ACC_W(14), .FIFO_DEPTH(8), .CLK_DIV(4), .HEADER(8'hA5)) dut1 (
    .clk(clk), .rst(rst1), .ch_i(ch_i1), .ch_q(ch_q1), .ch_ready(rdy1), .ovf_clr(clr1),
    .spi_clk(sclk1), .mosi(mosi1), .spi_ss(ss1), .overflow(ovf1), .fifo_level(lvl1),
    .busy(busy1), .fsm_state(st1));

  corr_spi_streamer #(.CHANNELS(4), .ACC_W(14), .FIFO_DEPTH(2), .CLK_DIV(1), .HEADER(8'hA5)) dut2 (
    .clk(clk), .rst(rst2), .ch_i(ch_i2), .ch_q(ch_q2), .ch_ready(rdy2), .ovf_clr(clr2),
    .spi_clk(sclk2), .mosi(mosi2), .spi_ss(ss2), .overflow(ovf2), .fifo_level(lvl2),
    .busy(busy2), .fsm_state(st2));

  // ---------------- scoreboard ----------------
  logic [55:0] exp_q[$];
  logic [55:0] rx1_q[$], rx2_q[$];
  int          low1_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SPI receivers (sample on falling clk edge) ----------------
  int          mon1_bits = 0, mon1_low = 0, peak1 = 0;
  bit          mon1_in = 0, mon1_pclk = 0;
  logic [55:0] mon1_sh = '0;
  always @(negedge clk) begin
    if (rst1) begin
      mon1_in = 0; mon1_bits = 0; mon1_pclk = 0;
    end else begin
      if (int'(lvl1) > peak1) peak1 = int'(lvl1);
      if (!ss1) begin
        if (!mon1_in) begin mon1_in = 1; mon1_bits = 0; mon1_low = 0; end
        mon1_low++;
        if (sclk1 && !mon1_pclk) begin mon1_sh = {mon1_sh[54:0], mosi1}; mon1_bits++; end
      end else if (mon1_in) begin
        mon1_in = 0;
        if (mon1_bits == 56) begin rx1_q.push_back(mon1_sh); low1_q.push_back(mon1_low); end
      end
      mon1_pclk = sclk1;
    end
  end

  int          mon2_bits = 0;
  bit          mon2_in = 0, mon2_pclk = 0;
  logic [55:0] mon2_sh = '0;
  always @(negedge clk) begin
    if (rst2) begin
      mon2_in = 0; mon2_bits = 0; mon2_pclk = 0;
    end else begin
      if (!ss2) begin
        if (!mon2_in) begin mon2_in = 1; mon2_bits = 0; end
        if (sclk2 && !mon2_pclk) begin mon2_sh = {mon2_sh[54:0], mosi2}; mon2_bits++; end
      end else if (mon2_in) begin
        mon2_in = 0;
        if (mon2_bits == 56) rx2_q.push_back(mon2_sh);
      end
      mon2_pclk = sclk2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set1(input int n, input logic [13:0] i, input logic [13:0] q);
    ch_i1[n*14 +: 14] = i;
    ch_q1[n*14 +: 14] = q;
  endtask

  task automatic pulse1(input logic [3:0] mask);
    tick(); rdy1 = mask;
    tick(); rdy1 = '0;
  endtask

  task automatic pulse2(input int n, input logic [13:0] i, input logic [13:0] q);
    tick(); ch_i2[n*14 +: 14] = i; ch_q2[n*14 +: 14] = q; rdy2 = 4'b0001 << n;
    tick(); rdy2 = '0;
  endtask

  task automatic reset1();
    tick(); rst1 = 1'b1;
    repeat (2) tick();
    rst1 = 1'b0;
    rx1_q.delete(); low1_q.delete();
  endtask

  task automatic reset2();
    tick(); rst2 = 1'b1;
    repeat (2) tick();
    rst2 = 1'b0;
    rx2_q.delete();
  endtask

  task automatic expect_frames(input bit sel, input int budget);
    int t = 0;
    int got;
    got = sel ? rx2_q.size() : rx1_q.size();
    while (got < exp_q.size() && t < budget) begin
      tick(); t++;
      got = sel ? rx2_q.size() : rx1_q.size();
    end
    check(sel ? "rx2_count" : "rx1_count", 64'(got), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got > 0) begin
      if (sel) check("frame2", 64'(rx2_q.pop_front()), 64'(exp_q.pop_front()));
      else     check("frame1", 64'(rx1_q.pop_front()), 64'(exp_q.pop_front()));
      got--;
    end
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    repeat (3) tick();
    check("rst_spi_clk", 64'(sclk1), 64'd0);
    check("rst_mosi", 64'(mosi1), 64'd0);
    check("rst_spi_ss", 64'(ss1), 64'd1);
    check("rst_overflow", 64'(ovf1), 64'd0);
    check("rst_fifo_level", 64'(lvl1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    rst1 = 1'b0;
    rst2 = 1'b0;
    tick();

    // Basic frame and capture-to-select latency
    set1(0, 14'h0123, 14'h3FFF);
    pulse1(4'b0001);
    tick();
    check("lat_level_c2", 64'(lvl1), 64'd1);
    check("lat_ss_c2", 64'(ss1), 64'd1);
    tick();
    check("lat_ss_c3", 64'(ss1), 64'd0);
    check("lat_mosi_c3", 64'(mosi1), 64'd1);
    check("lat_busy_c3", 64'(busy1), 64'd1);
    exp_q.push_back(56'hA5_00_00_0123_FFFF);
    expect_frames(1'b0, 700);
    check("ss_low_cycles", 64'(low1_q.size() > 0 ? low1_q.pop_front() : 0), 64'd456);

    // Sign extension
    set1(0, 14'h2000, 14'h1FFF);
    pulse1(4'b0001);
    exp_q.push_back(56'hA5_00_01_E000_1FFF);
    expect_frames(1'b0, 1200);

    // All four channels in one cycle
    reset1();
    set1(0, 14'h0001, 14'h0002);
    set1(1, 14'h0010, 14'h3FF0);
    set1(2, 14'h1000, 14'h2001);
    set1(3, 14'h3FFE, 14'h0ABC);
    peak1 = 0;
    pulse1(4'b1111);
    exp_q.push_back(56'hA5_00_00_0001_0002);
    exp_q.push_back(56'hA5_01_01_0010_FFF0);
    exp_q.push_back(56'hA5_02_02_1000_E001);
    exp_q.push_back(56'hA5_03_03_FFFE_0ABC);
    expect_frames(1'b0, 2600);
    check("peak_level", 64'(peak1), 64'd3);
    check("multi_overflow", 64'(ovf1), 64'd0);

    // Reset in the middle of the shift phase
    tick();
    set1(0, 14'h0555, 14'h0AAA);
    pulse1(4'b0001);
    t = 0;
    while (mon1_bits != 20 && t < 1000) begin tick(); t++; end
    check("reach_bit20", 64'(mon1_bits), 64'd20);
    check("pre_rst_sclk", 64'(sclk1), 64'd1);
    rst1 = 1'b1;
    #1;
    check("mid_rst_ss", 64'(ss1), 64'd1);
    check("mid_rst_sclk", 64'(sclk1), 64'd0);
    tick(); tick();
    rst1 = 1'b0;
    rx1_q.delete();
    tick();
    check("post_rst_level", 64'(lvl1), 64'd0);
    set1(0, 14'h0042, 14'h0007);
    pulse1(4'b0001);
    exp_q.push_back(56'hA5_00_00_0042_0007);
    expect_frames(1'b0, 700);

    // Overflow with a depth-2 FIFO behind a long frame
    reset2();
    for (int k = 1; k <= 4; k++) begin
      pulse2(1, 14'(k), 14'h0000);
      repeat (8) tick();
    end
    check("ovf_level_full", 64'(lvl2), 64'd2);
    check("ovf_before", 64'(ovf2), 64'd0);
    pulse2(1, 14'h0005, 14'h0000);
    check("ovf_set", 64'(ovf2), 64'd1);
    tick(); clr2 = 1'b1;
    tick(); clr2 = 1'b0;
    check("ovf_cleared", 64'(ovf2), 64'd0);
    exp_q.push_back(56'hA5_01_00_0001_0000);
    exp_q.push_back(56'hA5_01_01_0002_0000);
    exp_q.push_back(56'hA5_01_02_0003_0000);
    exp_q.push_back(56'hA5_01_03_0005_0000);
    expect_frames(1'b1, 800);

    // Sequence counter wrap over 257 frames
    reset2();
    for (int k = 0; k < 257; k++) begin
      logic [7:0] exp_seq;
      logic [55:0] f;
      exp_seq = 8'(k);
      pulse2(2, 14'h0000, 14'h0000);
      t = 0;
      while (rx2_q.size() == 0 && t < 400) begin tick(); t++; end
      if (rx2_q.size() == 0) begin
        check("wrap_timeout", 64'd0, 64'd1);
      end else begin
        f = rx2_q.pop_front();
        check("wrap_seq", 64'(f[39:32]), 64'(exp_seq));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
